// File: rtl/regfile_writeback.sv
// Write-port arbiter for the register file: ALU results take priority, long-latency
// results are buffered in a small FIFO or bypassed, and a busy scoreboard tracks pending writes.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_dest,
  input  logic [31:0]                alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [4:0]                 lsu_dest,
  input  logic [31:0]                lsu_data,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_dest,
  output logic                       reg_write,
  output logic [4:0]                 dest,
  output logic [31:0]                write_data,
  output logic [31:0]                busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg, count_next;

  logic          lsu_hs, fifo_empty, pop, bypass, push, sel_valid;
  logic [4:0]    sel_dest;
  logic [31:0]   sel_data;
  logic [31:0]   busy_reg, busy_next;

  assign lsu_ready  = (count_reg < FULL);
  assign fifo_empty = (count_reg == '0);
  assign lsu_hs     = lsu_valid & lsu_ready;
  assign pop        = ~alu_valid & ~fifo_empty;
  assign bypass     = ~alu_valid & fifo_empty & lsu_hs;
  assign push       = lsu_hs & ~bypass;
  assign sel_valid  = alu_valid | pop | bypass;

  always_comb begin
    sel_dest = lsu_dest;
    sel_data = lsu_data;
    if (alu_valid) begin
      sel_dest = alu_dest;
      sel_data = alu_data;
    end else if (pop) begin
      sel_dest = dest_mem[rd_ptr_reg];
      sel_data = data_mem[rd_ptr_reg];
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
  end

  // Per-register scoreboard: a same-cycle issue overrides the completing write.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_bit, clr_bit;
        assign set_bit = issue_valid && (issue_dest == 5'(gi));
        assign clr_bit = (pop || bypass) && (sel_dest == 5'(gi));
        assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_reg] <= lsu_dest;
      data_mem[wr_ptr_reg] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= '0;
      reg_write  <= 1'b0;
      dest       <= '0;
      write_data <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      busy_reg  <= busy_next;
      // x0 results are consumed but never written; data is zeroed for cleanliness.
      reg_write <= sel_valid && (sel_dest != 5'd0);
      if (sel_valid) begin
        dest       <= sel_dest;
        write_data <= (sel_dest == 5'd0) ? 32'd0 : sel_data;
      end
    end
  end

  assign busy       = busy_reg;
  assign fifo_count = count_reg;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU stream, bypass, FIFO contention,
// x0 handling, busy set/clear collision and asynchronous reset mid-operation.
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_dest, lsu_dest, issue_dest;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, reg_write;
  logic [4:0]  dest;
  logic [31:0] write_data, busy;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt, j;
  logic [31:0] exp_busy;
  logic acc;

  regfile_writeback #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .reg_write(reg_write), .dest(dest), .write_data(write_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    lsu_valid = 0; lsu_dest = 0; lsu_data = 0;
    issue_valid = 0; issue_dest = 0;
  endtask

  initial begin
    // Reset with random inputs
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'($urandom); alu_dest = 5'($urandom); alu_data = $urandom;
      lsu_valid = 1'($urandom); lsu_dest = 5'($urandom); lsu_data = $urandom;
      issue_valid = 1'($urandom); issue_dest = 5'($urandom);
      tick();
    end
    chk("rst_reg_write", reg_write, 0);
    chk("rst_dest", dest, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    idle();
    rst = 1;
    tick();
    chk("rst_lsu_ready", lsu_ready, 1);
    $display("reset: reg_write=%0b busy=%h fifo_count=%0d lsu_ready=%0b", reg_write, busy, fifo_count, lsu_ready);

    // ALU stream
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1; alu_dest = 5'(i); alu_data = 32'(i * 'h11);
      tick();
      chk("alu_reg_write", reg_write, 1);
      chk("alu_dest", dest, 32'(i));
      chk("alu_data", write_data, 32'(i * 'h11));
      chk("alu_busy", busy, 0);
      $display("alu: dest=%0d data=%h reg_write=%0b", dest, write_data, reg_write);
    end
    idle();
    tick();
    chk("alu_hold_one_cycle", reg_write, 0);

    // Bypass + scoreboard
    issue_valid = 1; issue_dest = 7;
    tick();
    idle();
    chk("byp_busy_set", busy, 32'h80);
    lsu_valid = 1; lsu_dest = 7; lsu_data = 32'hDEADBEEF;
    chk("byp_lsu_ready", lsu_ready, 1);
    tick();
    idle();
    chk("byp_reg_write", reg_write, 1);
    chk("byp_dest", dest, 7);
    chk("byp_data", write_data, 32'hDEADBEEF);
    chk("byp_busy_clear", busy, 0);
    chk("byp_fifo_count", fifo_count, 0);
    $display("bypass: dest=%0d data=%h busy=%h fifo_count=%0d", dest, write_data, busy, fifo_count);

    // Contention / full: mark 8..13 busy, then starve the FIFO with ALU traffic
    for (int i = 8; i <= 13; i++) begin
      issue_valid = 1; issue_dest = 5'(i);
      tick();
    end
    idle();
    exp_busy = 32'h3F00;
    chk("cont_busy_set", busy, exp_busy);
    exp_cnt = 0; j = 0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1; alu_dest = 20; alu_data = 32'h100 + 32'(c);
      lsu_valid = (j < 6); lsu_dest = 5'(8 + j); lsu_data = 32'hA00 + 32'(j);
      chk("cont_lsu_ready", lsu_ready, (exp_cnt < 4) ? 1 : 0);
      acc = lsu_valid && (exp_cnt < 4);
      tick();
      if (acc) begin exp_cnt++; j++; end
      chk("cont_fifo_count", fifo_count, 32'(exp_cnt));
      chk("cont_alu_dest", dest, 20);
      $display("contend: cycle=%0d fifo_count=%0d lsu_ready=%0b", c, fifo_count, lsu_ready);
    end
    chk("cont_full_not_ready", lsu_ready, 0);
    alu_valid = 0;
    for (int k = 0; k < 6; k++) begin
      lsu_valid = (j < 6); lsu_dest = 5'(8 + j); lsu_data = 32'hA00 + 32'(j);
      acc = lsu_valid && (exp_cnt < 4);
      tick();
      if (acc) begin exp_cnt++; j++; end
      exp_cnt--;
      exp_busy[8 + k] = 1'b0;
      chk("drain_reg_write", reg_write, 1);
      chk("drain_dest", dest, 32'(8 + k));
      chk("drain_data", write_data, 32'hA00 + 32'(k));
      chk("drain_fifo_count", fifo_count, 32'(exp_cnt));
      chk("drain_busy", busy, exp_busy);
      $display("drain: dest=%0d data=%h fifo_count=%0d busy=%h", dest, write_data, fifo_count, busy);
    end
    idle();
    tick();
    chk("drain_idle", reg_write, 0);
    chk("drain_empty", fifo_count, 0);

    // x0 rule
    alu_valid = 1; alu_dest = 0; alu_data = 32'h1234;
    tick();
    chk("x0_alu_reg_write", reg_write, 0);
    chk("x0_alu_data", write_data, 0);
    chk("x0_alu_dest", dest, 0);
    alu_valid = 1; alu_dest = 1; alu_data = 5;
    lsu_valid = 1; lsu_dest = 0; lsu_data = 32'h99;
    tick();
    idle();
    chk("x0_push_count", fifo_count, 1);
    chk("x0_alu1_write", reg_write, 1);
    tick();
    chk("x0_pop_reg_write", reg_write, 0);
    chk("x0_pop_data", write_data, 0);
    chk("x0_pop_count", fifo_count, 0);
    chk("x0_busy", busy, 0);
    $display("x0: reg_write=%0b write_data=%h fifo_count=%0d", reg_write, write_data, fifo_count);

    // Set/clear collision
    issue_valid = 1; issue_dest = 3;
    tick();
    chk("coll_busy_set", busy, 32'h8);
    issue_valid = 1; issue_dest = 3;
    lsu_valid = 1; lsu_dest = 3; lsu_data = 32'h33;
    tick();
    idle();
    chk("coll_write", reg_write, 1);
    chk("coll_dest", dest, 3);
    chk("coll_set_wins", busy, 32'h8);
    lsu_valid = 1; lsu_dest = 3; lsu_data = 32'h34;
    tick();
    idle();
    chk("coll_clear", busy, 0);
    $display("collision: busy=%h", busy);

    // Async reset mid-operation with FIFO half full
    alu_valid = 1; alu_dest = 2; alu_data = 32'h22;
    issue_valid = 1; issue_dest = 5;
    lsu_valid = 1; lsu_dest = 5; lsu_data = 32'h55;
    tick();
    issue_dest = 6; lsu_dest = 6; lsu_data = 32'h66;
    tick();
    idle();
    chk("mid_fifo_count", fifo_count, 2);
    chk("mid_busy", busy, 32'h60);
    rst = 0;
    #1;
    chk("async_fifo_count", fifo_count, 0);
    chk("async_busy", busy, 0);
    chk("async_reg_write", reg_write, 0);
    #2;
    rst = 1;
    tick();
    chk("post_rst_reg_write", reg_write, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_ready", lsu_ready, 1);
    $display("async reset: fifo_count=%0d busy=%h reg_write=%0b", fifo_count, busy, reg_write);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
